// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences column reads into a KxK line buffer and flags
// each cycle in which the line buffer's output holds a fresh window.
module line_buffer_ctrl #(
    parameter int unsigned KER_SIZE = 5,
    parameter int unsigned IMG_W    = 32,
    parameter int unsigned IMG_H    = 32,
    parameter int unsigned AW       = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          stall,
    output logic          rd_en,
    output logic [AW-1:0] rd_col,
    output logic [AW-1:0] rd_row,
    output logic [2:0]    col_ptr,
    output logic [2:0]    init_col_ptr,
    output logic          win_valid,
    output logic [AW-1:0] win_col,
    output logic [AW-1:0] win_row,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - KER_SIZE);
    localparam logic [AW-1:0] KM1_A    = AW'(KER_SIZE - 1);
    localparam logic [2:0]    KM1_P    = 3'(KER_SIZE - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_done_nxt;
    logic          w_issue;
    logic          w_last_issue;
    logic          w_accept;
    logic          w_win_issue;

    logic [AW-1:0] r_col;
    logic [AW-1:0] r_row;
    logic [2:0]    r_cmod;
    logic [2:0]    r_col_ptr;
    logic [2:0]    r_init_col_ptr;
    logic          r_v1;
    logic [AW-1:0] r_wcol1;
    logic [AW-1:0] r_wrow1;
    logic          r_win_valid;
    logic [AW-1:0] r_win_col;
    logic [AW-1:0] r_win_row;
    logic          r_busy;
    logic          r_done;

    // A start landing on the done cycle is dropped; the next cycle is accepted.
    assign w_accept     = (r_state == S_IDLE) && start && !r_done;
    assign w_issue      = (r_state == S_RUN) && !stall;
    assign w_last_issue = w_issue && (r_col == LAST_COL) && (r_row == LAST_ROW);
    assign w_win_issue  = w_issue && (r_col >= KM1_A);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; DRAIN ends once the final window has left the pipeline stage.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_v1) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Raster counters; they hold on stall and after the final issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col  <= '0;
            r_row  <= '0;
            r_cmod <= '0;
        end else if (w_accept) begin
            r_col  <= '0;
            r_row  <= '0;
            r_cmod <= '0;
        end else if (w_issue && !w_last_issue) begin
            if (r_col == LAST_COL) begin
                r_col  <= '0;
                r_cmod <= '0;
                r_row  <= r_row + AW'(1);
            end else begin
                r_col  <= r_col + AW'(1);
                r_cmod <= (r_cmod == KM1_P) ? 3'd0 : r_cmod + 3'd1;
            end
        end
    end

    // Data stage: slot pointers follow the read data by one cycle and hold between issues.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col_ptr      <= '0;
            r_init_col_ptr <= '0;
            r_v1           <= 1'b0;
            r_wcol1        <= '0;
            r_wrow1        <= '0;
        end else begin
            r_v1 <= w_win_issue;
            if (w_issue) begin
                r_col_ptr      <= r_cmod;
                r_init_col_ptr <= (r_col >= KM1_A) ? KM1_P : 3'(r_col);
            end
            if (w_win_issue) begin
                r_wcol1 <= r_col - KM1_A;
                r_wrow1 <= r_row;
            end
        end
    end

    // Window stage: coordinates hold whenever no new window is presented.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win_valid <= 1'b0;
            r_win_col   <= '0;
            r_win_row   <= '0;
        end else begin
            r_win_valid <= r_v1;
            if (r_v1) begin
                r_win_col <= r_wcol1;
                r_win_row <= r_wrow1;
            end
        end
    end

    // Job status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_done_nxt;
        end
    end

    // rd_en must react to stall in the same cycle, so it is a decode of state and stall.
    assign rd_en        = w_issue;
    assign rd_col       = r_col;
    assign rd_row       = r_row;
    assign col_ptr      = r_col_ptr;
    assign init_col_ptr = r_init_col_ptr;
    assign win_valid    = r_win_valid;
    assign win_col      = r_win_col;
    assign win_row      = r_win_row;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: small 3x3 over 5x4, single-band 5x5,
// and the default 32x32 frame with per-band stalls.
module tb_line_buffer_ctrl;
    localparam int unsigned AW = 8;

    logic clk;
    logic rstn;

    logic start_a, stall_a, start_b, stall_b, start_c, stall_c;

    logic          a_rd_en, a_wv, a_busy, a_done;
    logic [AW-1:0] a_rd_col, a_rd_row, a_wcol, a_wrow;
    logic [2:0]    a_col_ptr, a_init;

    logic          b_rd_en, b_wv, b_busy, b_done;
    logic [AW-1:0] b_rd_col, b_rd_row, b_wcol, b_wrow;
    logic [2:0]    b_col_ptr, b_init;

    logic          c_rd_en, c_wv, c_busy, c_done;
    logic [AW-1:0] c_rd_col, c_rd_row, c_wcol, c_wrow;
    logic [2:0]    c_col_ptr, c_init;

    int checks   = 0;
    int failures = 0;

    string SIG [10] = '{"rd_en", "rd_col", "rd_row", "col_ptr", "init_col_ptr",
                        "win_valid", "win_col", "win_row", "busy", "done"};

    // Hand-derived per-cycle traces; -1 marks a don't-care cycle.
    int T1 [10][17] = '{
        '{ 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0},
        '{-1, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4,-1,-1,-1,-1,-1,-1},
        '{-1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1,-1,-1,-1,-1,-1,-1},
        '{-1,-1, 0, 1, 2, 0, 1, 0, 1, 2, 0, 1, 1, 1, 1, 1, 1},
        '{-1,-1, 0, 1, 2, 2, 2, 0, 1, 2, 2, 2, 2, 2, 2, 2, 2},
        '{ 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0},
        '{-1,-1,-1,-1,-1, 0, 1, 2, 2, 2, 0, 1, 2, 2, 2, 2, 2},
        '{-1,-1,-1,-1,-1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1},
        '{ 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0},
        '{ 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0}
    };

    int T2 [10][17] = '{
        '{ 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0},
        '{-1, 0, 1,-1,-1, 2, 3, 4, 0, 1, 2, 3, 4,-1,-1,-1,-1},
        '{-1, 0, 0,-1,-1, 0, 0, 0, 1, 1, 1, 1, 1,-1,-1,-1,-1},
        '{-1,-1, 0, 1, 1, 1, 2, 0, 1, 0, 1, 2, 0, 1, 1, 1, 1},
        '{-1,-1, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 2, 2, 2, 2, 2},
        '{ 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0},
        '{-1,-1,-1,-1,-1,-1,-1, 0, 1, 2, 2, 2, 0, 1, 2, 2, 2},
        '{-1,-1,-1,-1,-1,-1,-1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1},
        '{ 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0},
        '{ 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}
    };

    line_buffer_ctrl #(.KER_SIZE(3), .IMG_W(5), .IMG_H(4), .AW(AW)) u_dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .stall(stall_a),
        .rd_en(a_rd_en), .rd_col(a_rd_col), .rd_row(a_rd_row),
        .col_ptr(a_col_ptr), .init_col_ptr(a_init),
        .win_valid(a_wv), .win_col(a_wcol), .win_row(a_wrow),
        .busy(a_busy), .done(a_done)
    );

    line_buffer_ctrl #(.KER_SIZE(5), .IMG_W(5), .IMG_H(5), .AW(AW)) u_dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .stall(stall_b),
        .rd_en(b_rd_en), .rd_col(b_rd_col), .rd_row(b_rd_row),
        .col_ptr(b_col_ptr), .init_col_ptr(b_init),
        .win_valid(b_wv), .win_col(b_wcol), .win_row(b_wrow),
        .busy(b_busy), .done(b_done)
    );

    line_buffer_ctrl #(.KER_SIZE(5), .IMG_W(32), .IMG_H(32), .AW(AW)) u_dut_c (
        .clk(clk), .rstn(rstn), .start(start_c), .stall(stall_c),
        .rd_en(c_rd_en), .rd_col(c_rd_col), .rd_row(c_rd_row),
        .col_ptr(c_col_ptr), .init_col_ptr(c_init),
        .win_valid(c_wv), .win_col(c_wcol), .win_row(c_wrow),
        .busy(c_busy), .done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Current value of one DUT-A output, by trace index.
    function automatic int obs_a(input int sig);
        int v;
        case (sig)
            0: v = int'(a_rd_en);
            1: v = int'(a_rd_col);
            2: v = int'(a_rd_row);
            3: v = int'(a_col_ptr);
            4: v = int'(a_init);
            5: v = int'(a_wv);
            6: v = int'(a_wcol);
            7: v = int'(a_wrow);
            8: v = int'(a_busy);
            default: v = int'(a_done);
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int o;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 10; s++) begin
            checks++;
            o = obs_a(s);
            if (o !== 0) begin
                failures++;
                $display("FAIL reset_a_%s got=%0d exp=0", SIG[s], o);
            end
        end
        checks++;
        if ({b_rd_en, b_busy, b_done, b_wv, b_init} !== 7'd0) begin
            failures++;
            $display("FAIL reset_b got=%0b exp=0", {b_rd_en, b_busy, b_done, b_wv, b_init});
        end
        checks++;
        if ({c_rd_en, c_busy, c_done, c_wv, c_init} !== 7'd0) begin
            failures++;
            $display("FAIL reset_c got=%0b exp=0", {c_rd_en, c_busy, c_done, c_wv, c_init});
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int e, o;
        for (int cyc = 0; cyc < 17; cyc++) begin
            start_a = (cyc == 0);
            stall_a = 1'b0;
            @(negedge clk);
            for (int s = 0; s < 10; s++) begin
                e = T1[s][cyc];
                if (e >= 0) begin
                    checks++;
                    o = obs_a(s);
                    if (o !== e) begin
                        failures++;
                        $display("FAIL basic_%s cyc=%0d got=%0d exp=%0d", SIG[s], cyc, o, e);
                    end
                end
            end
            tick();
        end
        start_a = 1'b0;
    endtask

    task automatic test_stall();
        int e, o;
        for (int cyc = 0; cyc < 17; cyc++) begin
            start_a = (cyc == 0);
            stall_a = (cyc == 3 || cyc == 4);
            @(negedge clk);
            for (int s = 0; s < 10; s++) begin
                e = T2[s][cyc];
                if (e >= 0) begin
                    checks++;
                    o = obs_a(s);
                    if (o !== e) begin
                        failures++;
                        $display("FAIL stall_%s cyc=%0d got=%0d exp=%0d", SIG[s], cyc, o, e);
                    end
                end
            end
            tick();
        end
        start_a = 1'b0;
        stall_a = 1'b0;
    endtask

    task automatic test_single_band();
        for (int cyc = 0; cyc < 11; cyc++) begin
            start_b = (cyc == 0);
            stall_b = 1'b0;
            @(negedge clk);
            checks++;
            if (b_rd_en !== (cyc >= 1 && cyc <= 5)) begin
                failures++;
                $display("FAIL band_rd_en cyc=%0d got=%0b", cyc, b_rd_en);
            end
            if (cyc >= 1 && cyc <= 5) begin
                checks++;
                if (int'(b_rd_col) !== cyc - 1 || b_rd_row !== 8'd0) begin
                    failures++;
                    $display("FAIL band_rd_addr cyc=%0d got=%0d,%0d exp=%0d,0", cyc, b_rd_col, b_rd_row, cyc - 1);
                end
            end
            if (cyc >= 2 && cyc <= 6) begin
                checks++;
                if (int'(b_col_ptr) !== cyc - 2 || int'(b_init) !== cyc - 2) begin
                    failures++;
                    $display("FAIL band_ptrs cyc=%0d got=%0d,%0d exp=%0d", cyc, b_col_ptr, b_init, cyc - 2);
                end
            end
            checks++;
            if (b_wv !== (cyc == 7)) begin
                failures++;
                $display("FAIL band_win_valid cyc=%0d got=%0b", cyc, b_wv);
            end
            if (cyc == 7) begin
                checks++;
                if (b_wcol !== 8'd0 || b_wrow !== 8'd0) begin
                    failures++;
                    $display("FAIL band_win_xy got=%0d,%0d exp=0,0", b_wcol, b_wrow);
                end
            end
            checks++;
            if (b_busy !== (cyc >= 1 && cyc <= 7) || b_done !== (cyc == 8)) begin
                failures++;
                $display("FAIL band_busy_done cyc=%0d got=%0b,%0b", cyc, b_busy, b_done);
            end
            tick();
        end
        start_b = 1'b0;
    endtask

    task automatic test_restart();
        int e, o;
        bit seen;
        for (int cyc = 0; cyc < 15; cyc++) begin
            start_a = (cyc == 0 || cyc == 4 || cyc == 13 || cyc == 14);
            stall_a = 1'b0;
            @(negedge clk);
            for (int s = 0; s < 10; s++) begin
                e = T1[s][cyc];
                if (e >= 0) begin
                    checks++;
                    o = obs_a(s);
                    if (o !== e) begin
                        failures++;
                        $display("FAIL restart_%s cyc=%0d got=%0d exp=%0d", SIG[s], cyc, o, e);
                    end
                end
            end
            tick();
        end
        start_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_busy, a_rd_en} !== 2'b11 || a_rd_col !== 8'd0 || a_rd_row !== 8'd0) begin
            failures++;
            $display("FAIL restart_job2_issue got=busy%0b,en%0b,%0d,%0d exp=1,1,0,0",
                     a_busy, a_rd_en, a_rd_col, a_rd_row);
        end
        tick();
        @(negedge clk);
        checks++;
        if (a_init !== 3'd0 || a_col_ptr !== 3'd0) begin
            failures++;
            $display("FAIL restart_job2_data got=%0d,%0d exp=0,0", a_init, a_col_ptr);
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            @(negedge clk);
            if (a_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL restart_job2_done got=0 exp=1");
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int e, o;
        for (int cyc = 0; cyc < 8; cyc++) begin
            start_a = (cyc == 0);
            @(negedge clk);
            for (int s = 0; s < 10; s++) begin
                e = T1[s][cyc];
                if (e >= 0) begin
                    checks++;
                    o = obs_a(s);
                    if (o !== e) begin
                        failures++;
                        $display("FAIL rstmid_pre_%s cyc=%0d got=%0d exp=%0d", SIG[s], cyc, o, e);
                    end
                end
            end
            tick();
        end
        start_a = 1'b0;
        rstn = 1'b0;
        #1;
        for (int s = 0; s < 10; s++) begin
            checks++;
            o = obs_a(s);
            if (o !== 0) begin
                failures++;
                $display("FAIL rstmid_%s got=%0d exp=0", SIG[s], o);
            end
        end
        tick();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_done !== 1'b0 || a_busy !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_idle i=%0d got=done%0b,busy%0b exp=0,0", i, a_done, a_busy);
            end
            tick();
        end
        for (int cyc = 0; cyc < 17; cyc++) begin
            start_a = (cyc == 0);
            @(negedge clk);
            for (int s = 0; s < 10; s++) begin
                e = T1[s][cyc];
                if (e >= 0) begin
                    checks++;
                    o = obs_a(s);
                    if (o !== e) begin
                        failures++;
                        $display("FAIL rstmid_post_%s cyc=%0d got=%0d exp=%0d", SIG[s], cyc, o, e);
                    end
                end
            end
            tick();
        end
        start_a = 1'b0;
    endtask

    task automatic test_full_frame();
        int  nwin, niss, ex, ey, prev_init, stalled_row;
        bit  seen_done;
        nwin = 0; niss = 0; ex = 0; ey = 0; prev_init = 0; stalled_row = -1; seen_done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            start_c = (cyc == 0);
            stall_c = c_busy && (c_rd_col == 8'd4) && (int'(c_rd_row) != stalled_row);
            if (stall_c) stalled_row = int'(c_rd_row);
            @(negedge clk);
            if (stall_c) begin
                checks++;
                if (c_rd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_stall_rd_en cyc=%0d got=1 exp=0", cyc);
                end
            end
            if (c_rd_en) niss++;
            if (c_wv) begin
                checks++;
                if (int'(c_wcol) !== ex || int'(c_wrow) !== ey) begin
                    failures++;
                    $display("FAIL frame_win_xy n=%0d got=%0d,%0d exp=%0d,%0d", nwin, c_wcol, c_wrow, ex, ey);
                end
                checks++;
                if (prev_init !== 4) begin
                    failures++;
                    $display("FAIL frame_fill n=%0d got=%0d exp=4", nwin, prev_init);
                end
                nwin++;
                ex++;
                if (ex == 28) begin
                    ex = 0;
                    ey++;
                end
            end
            if (c_done) seen_done = 1'b1;
            prev_init = int'(c_init);
            tick();
        end
        start_c = 1'b0;
        stall_c = 1'b0;
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL frame_done got=0 exp=1");
        end
        checks++;
        if (nwin !== 784) begin
            failures++;
            $display("FAIL frame_windows got=%0d exp=784", nwin);
        end
        checks++;
        if (niss !== 896) begin
            failures++;
            $display("FAIL frame_issues got=%0d exp=896", niss);
        end
    endtask

    initial begin
        start_a = 1'b0; stall_a = 1'b0;
        start_b = 1'b0; stall_b = 1'b0;
        start_c = 1'b0; stall_c = 1'b0;
        rstn    = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_single_band();
        test_restart();
        test_reset_mid();
        test_full_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
